rs232_tx_arbiter: RTL and testbench
===================================

RS232_TX_ARBITER -- requirements
Module: rs232_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16'd3840, is the stall limit in clock cycles (200 ms at 19.2 kHz).
REQ-002 clock  input  1  19.2 kHz system clock clock_00_0192.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester has a byte offered.
REQ-005 req0_byte / req1_byte  input  8 each  offered byte.
REQ-006 req0_last / req1_last  input  1 each  offered byte is the final byte of its packet.
REQ-007 req0_ready / req1_ready  output  1 each  byte accepted this cycle.
REQ-008 tx_busy  input  1  UART encoder is shifting a frame.
REQ-009 tx_start  output  1  one-cycle load strobe to the encoder.
REQ-010 tx_byte  output  8  byte presented to the encoder.
REQ-011 grant  output  2  one-hot packet owner; 2'b00 when idle.
REQ-012 timeout_err  output  1  one-cycle pulse when a packet is aborted.
REQ-013 err_count  output  8  saturating count of aborts.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, WAIT_ACK and WAIT_DONE; all registers SHALL be clocked on the rising edge of clock.
REQ-015 In IDLE, when exactly one reqN_valid is high, the block SHALL set grant to that requester and enter SEND on the next edge.
REQ-016 In IDLE, when both valids are high, the block SHALL grant the requester not served last (round-robin); the pointer after reset SHALL favour req0.
REQ-017 Grant SHALL be held for the whole packet, through the accepted byte with last=1; the other requester SHALL see ready=0 throughout.
REQ-018 reqN_ready SHALL be combinational, high only when state=SEND, grant selects N, reqN_valid=1 and tx_busy=0; a transfer is valid&ready in the same cycle.
REQ-019 On a transfer the block SHALL register tx_byte, capture last, pulse tx_start high for exactly one cycle (the next cycle), and enter WAIT_ACK.
REQ-020 In WAIT_ACK the block SHALL wait for tx_busy=1, then enter WAIT_DONE.
REQ-021 In WAIT_DONE the block SHALL wait for tx_busy=0; then, if the captured last=1, it SHALL clear grant, flip the round-robin pointer to the other requester and enter IDLE; otherwise it SHALL return to SEND.
REQ-022 Transfer-to-next-tx_start latency SHALL be 1 cycle, and no two tx_start pulses SHALL occur without an intervening tx_busy high-to-low transition.
REQ-023 A 16-bit stall counter SHALL clear on every state change and increment each cycle while in SEND, WAIT_ACK or WAIT_DONE.
REQ-024 When the stall counter reaches TIMEOUT, the block SHALL abort the packet: grant=2'b00, pointer flipped, next state IDLE, timeout_err pulsed for 1 cycle, err_count incremented (saturating at 8'hFF).
REQ-025 A requester dropping valid mid-packet SHALL NOT release grant; only last=1 or a timeout SHALL release it.
REQ-026 A byte with last=1 on the first byte SHALL be treated as a one-byte packet.
REQ-027 tx_byte SHALL hold its value until the next transfer.
REQ-028 tx_busy already high when SEND is entered SHALL block ready until it falls.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, grant=2'b00, tx_start=0, tx_byte=8'h00, ready outputs=0, timeout_err=0, err_count=8'h00, stall counter=0 and pointer=req0, including mid-packet.
REQ-030 After reset deasserts, the first arbitration SHALL occur on the first rising edge with any valid high.

Verification
REQ-031 Single packet: req0 sends 8'hA5 then 8'h3C(last), encoder model busy 20 cycles -> two tx_start pulses carrying A5 then 3C, grant=01 until the second busy falls, then 00.
REQ-032 Contention: both valid from reset -> req0 is served first (full 3-byte packet), then req1; repeated contention alternates 01,10,01.
REQ-033 Lockout: req1 asserts valid mid-req0-packet -> req1_ready stays 0 until req0's last byte completes.
REQ-034 Stall: req0 sends a non-last byte then drops valid -> after TIMEOUT cycles timeout_err pulses once, err_count=1, grant=00, and a pending req1 is granted next.
REQ-035 Dead encoder: tx_busy never rises -> abort after TIMEOUT cycles in WAIT_ACK; 256 aborts -> err_count holds 8'hFF.
REQ-036 Reset during WAIT_DONE -> all outputs reach their reset values without waiting for a clock edge, and no tx_start is issued after release until a new request arrives.

Source files
------------

// File: rtl/rs232_tx_arbiter.sv
// Two-requester packet arbiter in front of a UART encoder: round-robin packet grant,
// one-byte load handshake with the encoder, and a stall watchdog that aborts hung packets.
module rs232_tx_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd3840
) (
    input  logic       clock_00_0192,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_byte,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_byte,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic [1:0] grant,
    output logic       timeout_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  grant_next;
    logic        ptr, ptr_next;          // 0 favours req0 on contention, 1 favours req1
    logic        last_q, last_next;
    logic [7:0]  tx_byte_next;
    logic        tx_start_next;
    logic        timeout_err_next;
    logic [7:0]  err_count_next;
    logic [15:0] stall, stall_next;
    logic        xfer;
    logic [7:0]  sel_byte;
    logic        sel_last;

    assign req0_ready = (state == SEND) && grant[0] && req0_valid && !tx_busy;
    assign req1_ready = (state == SEND) && grant[1] && req1_valid && !tx_busy;
    assign xfer       = req0_ready || req1_ready;
    assign sel_byte   = req1_ready ? req1_byte : req0_byte;
    assign sel_last   = req1_ready ? req1_last : req0_last;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_next       = state;
        grant_next       = grant;
        ptr_next         = ptr;
        last_next        = last_q;
        tx_byte_next     = tx_byte;
        tx_start_next    = 1'b0;
        timeout_err_next = 1'b0;
        err_count_next   = err_count;

        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !ptr)) begin
                    grant_next = 2'b01;
                    state_next = SEND;
                end else if (req1_valid) begin
                    grant_next = 2'b10;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    tx_byte_next  = sel_byte;
                    last_next     = sel_last;
                    tx_start_next = 1'b1;
                    state_next    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_next = 2'b00;
                        ptr_next   = grant[0];
                        state_next = IDLE;
                    end else begin
                        state_next = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Normal progress wins; the watchdog only fires when the state is going nowhere.
        if (state != IDLE && state_next == state && stall == TIMEOUT) begin
            state_next       = IDLE;
            grant_next       = 2'b00;
            ptr_next         = grant[0];
            timeout_err_next = 1'b1;
            if (err_count != 8'hFF) err_count_next = err_count + 8'd1;
        end

        if (state_next != state)  stall_next = 16'd0;
        else if (state != IDLE)   stall_next = stall + 16'd1;
        else                      stall_next = stall;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and clears
    // every register, including mid-packet.
    always_ff @(posedge clock_00_0192 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'b00;
            ptr         <= 1'b0;
            last_q      <= 1'b0;
            tx_byte     <= 8'h00;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            err_count   <= 8'h00;
            stall       <= 16'd0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            ptr         <= ptr_next;
            last_q      <= last_next;
            tx_byte     <= tx_byte_next;
            tx_start    <= tx_start_next;
            timeout_err <= timeout_err_next;
            err_count   <= err_count_next;
            stall       <= stall_next;
        end
    end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: single packet, round-robin contention, lockout,
// stall abort, dead encoder with err_count saturation, and reset during WAIT_DONE.
module tb_rs232_tx_arbiter;

    localparam logic [15:0] TO = 16'd60;

    logic       clock_00_0192;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_byte, req1_byte;
    logic       req0_last, req1_last;
    logic       req0_ready, req1_ready;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [1:0] grant;
    logic       timeout_err;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    // Encoder model and monitor state
    int         busy_len = 5;
    bit         enc_on = 1;
    int         busy_cnt;
    int         starts = 0;
    int         terr_pulses = 0;
    int         lock_viol = 0;
    int         proto_viol = 0;
    bit         fell = 1;
    logic       busy_prev = 0;
    logic [7:0] sq[$];

    rs232_tx_arbiter #(.TIMEOUT(TO)) dut (
        .clock_00_0192(clock_00_0192),
        .reset(reset),
        .req0_valid(req0_valid),
        .req0_byte(req0_byte),
        .req0_last(req0_last),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_byte(req1_byte),
        .req1_last(req1_last),
        .req1_ready(req1_ready),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_byte(tx_byte),
        .grant(grant),
        .timeout_err(timeout_err),
        .err_count(err_count)
    );

    initial begin
        clock_00_0192 = 1'b0;
        forever #5 clock_00_0192 = ~clock_00_0192;
    end

    // Encoder: picks up tx_start on the falling edge and stays busy for busy_len falling edges.
    initial begin
        tx_busy  = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clock_00_0192);
            if (reset) begin
                busy_cnt = 0;
                tx_busy  = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end else if (tx_start && enc_on) begin
                tx_busy  = 1'b1;
                busy_cnt = busy_len;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock_00_0192);
            #3;
            if ((req0_ready && grant != 2'b01) || (req1_ready && grant != 2'b10)) lock_viol++;
            if (busy_prev && !tx_busy) fell = 1;
            busy_prev = tx_busy;
            if (tx_start) begin
                starts++;
                sq.push_back(tx_byte);
                if (!fell) proto_viol++;
                fell = 0;
            end
            if (timeout_err) terr_pulses++;
            if (timeout_err || reset) fell = 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock_00_0192);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock_00_0192);
        #1;
        reset = 1'b0;
    endtask

    // Offers one byte, waits for the handshake, returns 1 time unit after the transfer edge.
    task automatic send(input int who, input logic [7:0] b, input logic l);
        int n = 0;
        if (who == 0) begin
            req0_valid = 1'b1; req0_byte = b; req0_last = l;
        end else begin
            req1_valid = 1'b1; req1_byte = b; req1_last = l;
        end
        #1;
        while (!(who == 0 ? req0_ready : req1_ready) && n < 300) begin
            step(1);
            n++;
        end
        check("ready_seen", {15'd0, (who == 0 ? req0_ready : req1_ready)}, 16'd1);
        step(1);
        if (who == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        check("tx_start_after_xfer", {15'd0, tx_start}, 16'd1);
        check("tx_byte", {8'd0, tx_byte}, {8'd0, b});
    endtask

    // Waits for the current owner to release, then for the next grant, and checks its owner.
    task automatic next_owner(input string tag, input logic [1:0] exp);
        int n = 0;
        while (grant != 2'b00 && n < 300) begin step(1); n++; end
        while (grant == 2'b00 && n < 600) begin step(1); n++; end
        check(tag, {14'd0, grant}, {14'd0, exp});
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (grant != 2'b00 && n < 300) begin step(1); n++; end
        check("idle_reached", {14'd0, grant}, 16'd0);
    endtask

    task automatic wait_terr(output int n);
        n = 0;
        while (!timeout_err && n < 1000) begin step(1); n++; end
        check("timeout_err_seen", {15'd0, timeout_err}, 16'd1);
    endtask

    initial begin
        int n;
        int s0;
        int t0;
        logic [7:0] b;

        reset = 1'b1;
        req0_valid = 1'b0; req0_byte = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_byte = 8'h00; req1_last = 1'b0;
        #2;
        check("rst_grant", {14'd0, grant}, 16'd0);
        check("rst_tx_start", {15'd0, tx_start}, 16'd0);
        check("rst_tx_byte", {8'd0, tx_byte}, 16'd0);
        check("rst_err_count", {8'd0, err_count}, 16'd0);
        check("rst_timeout_err", {15'd0, timeout_err}, 16'd0);
        check("rst_ready", {14'd0, req1_ready, req0_ready}, 16'd0);
        do_reset();

        // Single packet A5, 3C(last) with a 20-cycle encoder
        busy_len = 20;
        send(0, 8'hA5, 1'b0);
        check("p1_grant", {14'd0, grant}, 16'h1);
        send(0, 8'h3C, 1'b1);
        check("p1_grant_held", {14'd0, grant}, 16'h1);
        wait_idle(n);
        check("p1_release_latency", n[15:0], 16'd21);
        check("p1_start_count", starts[15:0], 16'd2);
        check("p1_byte0", {8'd0, sq[0]}, 16'hA5);
        check("p1_byte1", {8'd0, sq[1]}, 16'h3C);
        check("p1_tx_byte_hold", {8'd0, tx_byte}, 16'h3C);
        check("p1_no_timeout", terr_pulses[15:0], 16'd0);

        // Contention from reset, lockout, then round-robin 01,10,01,10
        busy_len = 5;
        do_reset();
        req1_valid = 1'b1; req1_byte = 8'h44; req1_last = 1'b0;
        send(0, 8'h11, 1'b0);
        check("c_first_owner", {14'd0, grant}, 16'h1);
        send(0, 8'h22, 1'b0);
        send(0, 8'h33, 1'b1);
        next_owner("c_second_owner", 2'b10);
        send(1, 8'h44, 1'b0);
        req0_valid = 1'b1; req0_byte = 8'h66; req0_last = 1'b1;
        send(1, 8'h55, 1'b1);
        req1_valid = 1'b1; req1_byte = 8'h77; req1_last = 1'b1;
        next_owner("c_third_owner", 2'b01);
        send(0, 8'h66, 1'b1);
        next_owner("c_fourth_owner", 2'b10);
        send(1, 8'h77, 1'b1);
        wait_idle(n);
        check("c_lockout", lock_viol[15:0], 16'd0);
        check("c_order_len", sq.size(), 16'd9);
        check("c_order_b3", {8'd0, sq[5]}, 16'h44);
        check("c_order_b5", {8'd0, sq[7]}, 16'h66);

        // Stall: req0 drops valid mid-packet while req1 waits
        do_reset();
        t0 = terr_pulses;
        send(0, 8'h5A, 1'b0);
        req1_valid = 1'b1; req1_byte = 8'h99; req1_last = 1'b1;
        wait_terr(n);
        check("s_abort_latency", n[15:0], 16'd67);
        check("s_err_count", {8'd0, err_count}, 16'd1);
        check("s_grant_cleared", {14'd0, grant}, 16'd0);
        step(1);
        check("s_pulse_one_cycle", {15'd0, timeout_err}, 16'd0);
        next_owner("s_pending_granted", 2'b10);
        send(1, 8'h99, 1'b1);
        wait_idle(n);
        check("s_pulse_count", (terr_pulses - t0), 16'd1);

        // Dead encoder: 256 aborts from WAIT_ACK
        do_reset();
        enc_on = 1'b0;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            send(0, b, 1'b1);
            wait_terr(n);
            if (i == 0) begin
                check("d_abort_latency", n[15:0], 16'd61);
                check("d_err_first", {8'd0, err_count}, 16'd1);
            end
            if (i == 254) check("d_err_255", {8'd0, err_count}, 16'hFF);
        end
        check("d_err_saturated", {8'd0, err_count}, 16'hFF);
        enc_on = 1'b1;

        // Reset in WAIT_DONE takes effect without a clock edge
        busy_len = 20;
        send(0, 8'hC3, 1'b0);
        step(5);
        check("r_owner_before", {14'd0, grant}, 16'h1);
        #1;
        reset = 1'b1;
        #1;
        check("r_async_grant", {14'd0, grant}, 16'd0);
        check("r_async_tx_byte", {8'd0, tx_byte}, 16'd0);
        check("r_async_err_count", {8'd0, err_count}, 16'd0);
        check("r_async_start_terr", {14'd0, tx_start, timeout_err}, 16'd0);
        repeat (2) @(posedge clock_00_0192);
        #1;
        reset = 1'b0;
        s0 = starts;
        step(40);
        check("r_no_start_after", (starts - s0), 16'd0);
        check("r_idle_after", {14'd0, grant}, 16'd0);
        check("protocol_busy_between_starts", proto_viol[15:0], 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
